// File: rtl/comparator_rr_scheduler.sv
// -----------------------------------------------------------------------------
// comparator_rr_scheduler
//   Shares a single unsigned magnitude comparator between NREQ requesters.
//   Requesters are granted in round-robin order. The winner's operands are
//   registered, compared in the following cycle, and the result is returned
//   tagged with the requester index on a valid/ready response channel.
//
//   Sequence per request: IDLE (grant) -> COMPARE -> RESPOND (wait rsp_ready).
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_valid [NREQ]  per-requester request strobe
//   req_ready [NREQ]  one-hot accept pulse, valid only in IDLE
//   req_a, req_b      packed operands, requester i on [i*WIDTH +: WIDTH]
//   rsp_valid         result available (RESPOND)
//   rsp_ready         consumer accepts result
//   rsp_id            requester that owns the result
//   rsp_equal/greater/lesser  registered compare result, 0 when !rsp_valid
//   busy              FSM not in IDLE
// -----------------------------------------------------------------------------

// Plain combinational magnitude comparator; the one shared datapath.
//   a_i, b_i    unsigned operands
//   eq_o/gt_o/lt_o  exactly one is set
module magnitude_comparator #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             eq_o,
   output logic             gt_o,
   output logic             lt_o
);
   assign eq_o = (a_i == b_i);
   assign gt_o = (a_i >  b_i);
   assign lt_o = (a_i <  b_i);
endmodule

module comparator_rr_scheduler #(
   parameter int WIDTH = 5,
   parameter int NREQ  = 4,
   parameter int ID_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_equal,
   output logic                  rsp_greater,
   output logic                  rsp_lesser,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_RESPOND
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              eq_q, eq_d;
   logic              gt_q, gt_d;
   logic              lt_q, lt_d;

   logic              cmp_eq, cmp_gt, cmp_lt;
   logic [NREQ-1:0]   rot_valid;
   logic [NREQ-1:0]   grant_vec;
   logic              any_valid;
   logic [ID_W:0]     win_sum;
   logic [ID_W-1:0]   winner;
   logic [ID_W:0]     ptr_nxt;

   // ---------------------------------------------------------------------------
   // Round-robin arbiter
   //   Rotate the request vector so the pointer lands on bit 0, pick the lowest
   //   set bit, then add the pointer back (mod NREQ) to get the real index.
   //   The served requester's successor becomes the new top priority, so a
   //   requester that re-requests right away queues behind everyone else.
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default before any
   // conditional logic; a path that leaves one unassigned would infer a latch.
   always_comb begin
      rot_valid = NREQ'({req_valid, req_valid} >> ptr_q);
      any_valid = |rot_valid;
      win_sum   = '0;
      // Descending scan: the last hit, i.e. the lowest offset, wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) win_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      end
      if (win_sum >= (ID_W+1)'(NREQ)) win_sum = win_sum - (ID_W+1)'(NREQ);
      winner  = win_sum[ID_W-1:0];

      ptr_nxt = {1'b0, winner} + (ID_W+1)'(1);
      if (ptr_nxt >= (ID_W+1)'(NREQ)) ptr_nxt = '0;

      grant_vec = '0;
      for (int i = 0; i < NREQ; i++) begin
         grant_vec[i] = any_valid && (winner == ID_W'(i));
      end
   end

   // Single shared comparator, fed only from the latched operands.
   magnitude_comparator #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .a_i  (a_q),
      .b_i  (b_q),
      .eq_o (cmp_eq),
      .gt_o (cmp_gt),
      .lt_o (cmp_lt)
   );

   // ---------------------------------------------------------------------------
   // FSM next-state and datapath loads
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      a_d     = a_q;
      b_d     = b_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;

      unique case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               state_d = S_COMPARE;
               id_d    = winner;
               ptr_d   = ptr_nxt[ID_W-1:0];
               for (int i = 0; i < NREQ; i++) begin
                  if (grant_vec[i]) begin
                     a_d = req_a[i*WIDTH +: WIDTH];
                     b_d = req_b[i*WIDTH +: WIDTH];
                  end
               end
            end
         end
         S_COMPARE: begin
            eq_d    = cmp_eq;
            gt_d    = cmp_gt;
            lt_d    = cmp_lt;
            state_d = S_RESPOND;
         end
         S_RESPOND: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order the simulator runs blocks.
   // The operand/result registers are reset as well: they are only a handful of
   // flops, and it keeps every output at a known 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   //   req_ready is combinational from req_valid, so it is masked with rst_n to
   //   stay 0 while reset is held even though the FSM already sits in IDLE.
   // ---------------------------------------------------------------------------
   assign req_ready   = (state_q == S_IDLE) ? (grant_vec & {NREQ{rst_n}}) : '0;
   assign rsp_valid   = (state_q == S_RESPOND);
   assign rsp_id      = id_q;
   assign rsp_equal   = rsp_valid & eq_q;
   assign rsp_greater = rsp_valid & gt_q;
   assign rsp_lesser  = rsp_valid & lt_q;
   assign busy        = (state_q != S_IDLE);

endmodule
